// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - time-multiplexed BCD digit scanner for a shared 7-segment decoder
//
// Purpose: steps through DIGITS display positions, SCAN_DIV clocks each,
// presenting one BCD nibble and a one-hot digit enable per position.
// New values are held pending and swapped into the display only at a
// frame boundary so a frame never shows a mix of old and new digits.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   load       one-cycle strobe capturing digits_in as the pending value
//   digits_in  packed BCD, nibble i at [4i+3:4i], digit 0 least significant
//   blank_en   level: blank leading zeros
//   number     registered digit code to the segment decoder
//   dig_sel    registered one-hot digit enable (inverted if SEL_ACTIVE_LOW)
//   updated    one-cycle pulse when a pending value reaches the display
module bcd_display_scanner #(
    parameter int          DIGITS         = 6,
    parameter int          SCAN_DIV       = 50000,
    parameter logic [3:0]  BLANK_CODE     = 4'hF,
    parameter bit          SEL_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic                  blank_en,
    output logic [3:0]            number,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  updated
);

    localparam int                CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int                IW       = $clog2(DIGITS);
    localparam logic [CW-1:0]     CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] SEL_OFF  = {DIGITS{SEL_ACTIVE_LOW}};

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   disp;
    logic [4*DIGITS-1:0]   pend;
    logic                  pend_valid;

    logic                  tick;
    logic                  frame_end;
    logic                  commit;
    logic [3:0]            cur_digit;
    logic                  blank_cur;
    logic [DIGITS-1:0]     sel_hot;

    assign tick      = (cnt == CNT_LAST);
    assign frame_end = tick && (idx == IDX_LAST);
    assign commit    = frame_end && pend_valid;

    // Prescaler and scan position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
        end
    end

    // Pending/display double buffer. A load coinciding with a commit still
    // lands in pend: the old pending value goes to the display and the new
    // one waits for the next frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp       <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
        end else begin
            if (commit) begin
                disp <= pend;
            end
            if (load) begin
                pend       <= digits_in;
                pend_valid <= 1'b1;
            end else if (commit) begin
                pend_valid <= 1'b0;
            end
        end
    end

    // Current digit select and blanking. A digit is a leading zero when it
    // and every more significant nibble are zero; codes 10..15 count as
    // non-zero so they stop blanking like any other digit.
    always_comb begin
        cur_digit = 4'h0;
        sel_hot   = '0;
        blank_cur = blank_en && (idx != '0);
        for (int j = 0; j < DIGITS; j++) begin
            if (IW'(j) == idx) begin
                cur_digit  = disp[4*j +: 4];
                sel_hot[j] = 1'b1;
            end
            if ((IW'(j) >= idx) && (disp[4*j +: 4] != 4'h0)) begin
                blank_cur = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            number  <= BLANK_CODE;
            dig_sel <= SEL_OFF;
            updated <= 1'b0;
        end else begin
            number  <= blank_cur ? BLANK_CODE : cur_digit;
            dig_sel <= sel_hot ^ SEL_OFF;
            updated <= commit;
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb/tb_bcd_display_scanner.sv - self-checking bench for bcd_display_scanner
module tb_bcd_display_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_a = 1'b0;
    logic        load_b = 1'b0;
    logic        blank_en = 1'b1;
    logic [15:0] digits_in = 16'h0;
    logic [3:0]  number_a, number_b, sel_a, sel_b;
    logic        upd_a, upd_b;

    int vectors = 0;
    int miscompares = 0;
    int ncyc = 0;
    int upd_cnt_a = 0;
    int upd_last_a = 0;
    int upd_prev_a = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    bcd_display_scanner #(.DIGITS(4), .SCAN_DIV(4), .BLANK_CODE(4'hF), .SEL_ACTIVE_LOW(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .load(load_a), .digits_in(digits_in), .blank_en(blank_en),
        .number(number_a), .dig_sel(sel_a), .updated(upd_a)
    );

    bcd_display_scanner #(.DIGITS(4), .SCAN_DIV(1), .BLANK_CODE(4'hF), .SEL_ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .load(load_b), .digits_in(digits_in), .blank_en(blank_en),
        .number(number_b), .dig_sel(sel_b), .updated(upd_b)
    );

    // Reference model: position and frame boundaries follow from the cycle
    // count k since reset release; outputs after an edge describe position
    // (k / SCAN_DIV) % 4 using the display contents before that edge.
    typedef struct packed {
        int          k;
        logic [15:0] disp;
        logic [15:0] pend;
        logic        pv;
        logic [3:0]  num;
        logic [3:0]  sel;
        logic        upd;
    } ms_t;

    ms_t ms_a, ms_b;

    function automatic ms_t m_reset(bit al);
        ms_t s;
        s = '0;
        s.num = 4'hF;
        s.sel = al ? 4'hF : 4'h0;
        return s;
    endfunction

    function automatic ms_t m_step(ms_t s, int sd, bit al, bit ld, logic [15:0] din, bit ben);
        ms_t n;
        int  pos;
        bit  bnd;
        n   = s;
        pos = (s.k / sd) % 4;
        bnd = (s.k % (4 * sd)) == (4 * sd - 1);
        n.sel = 4'(1 << pos) ^ (al ? 4'hF : 4'h0);
        n.num = (ben && pos > 0 && (s.disp >> (4 * pos)) == 16'h0) ? 4'hF : s.disp[4*pos +: 4];
        n.upd = bnd && s.pv;
        if (bnd && s.pv) begin
            n.disp = s.pend;
            n.pv   = 1'b0;
        end
        if (ld) begin
            n.pend = din;
            n.pv   = 1'b1;
        end
        n.k = s.k + 1;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms_a <= m_reset(1'b0);
            ms_b <= m_reset(1'b1);
        end else begin
            ms_a <= m_step(ms_a, 4, 1'b0, load_a, digits_in, blank_en);
            ms_b <= m_step(ms_b, 1, 1'b1, load_b, digits_in, blank_en);
        end
    end

    task automatic cmp_inst(string nm, logic [3:0] n, logic [3:0] s, logic u, ms_t e);
        vectors++;
        if ({n, s, u} !== {e.num, e.sel, e.upd}) begin
            miscompares++;
            $display("FAIL %s cycle %0d: number/dig_sel/updated = %h/%b/%b, required %h/%b/%b",
                     nm, ncyc, n, s, u, e.num, e.sel, e.upd);
        end
    endtask

    always @(negedge clk) begin
        ncyc++;
        if (upd_a === 1'b1) begin
            upd_cnt_a++;
            upd_prev_a = upd_last_a;
            upd_last_a = ncyc;
        end
        if (chk_en) begin
            cmp_inst("model_a", number_a, sel_a, upd_a, ms_a);
            cmp_inst("model_b", number_b, sel_b, upd_b, ms_b);
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [3:0] sel_of(int inst);
        return (inst == 0) ? sel_a : sel_b;
    endfunction

    function automatic logic [3:0] num_of(int inst);
        return (inst == 0) ? number_a : number_b;
    endfunction

    function automatic logic [3:0] sel_exp(int inst, int d);
        logic [3:0] oh;
        oh = 4'(1 << d);
        return (inst == 0) ? oh : ~oh;
    endfunction

    // Advance to the first sample of a new frame (digit 0 freshly selected).
    task automatic wait_start(int inst);
        logic [3:0] prev, cur;
        bit found;
        found = 1'b0;
        prev  = sel_of(inst);
        for (int b = 0; b < 200 && !found; b++) begin
            tick();
            cur = sel_of(inst);
            if (cur == sel_exp(inst, 0) && prev != sel_exp(inst, 0)) found = 1'b1;
            prev = cur;
        end
        if (!found) chk("frame_start_timeout", 32'd1, 32'd0);
    endtask

    // Capture one whole frame as a packed value, digit d at nibble d.
    task automatic grab(int inst, output logic [15:0] val, output int fstart);
        int sd;
        sd  = (inst == 0) ? 4 : 1;
        val = 16'h0;
        wait_start(inst);
        fstart = ncyc;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("frame_sel_%0d_d%0d", inst, d), 32'(sel_of(inst)), 32'(sel_exp(inst, d)));
            val[4*d +: 4] = num_of(inst);
            if (d < 3) repeat (sd) tick();
        end
    endtask

    task automatic pulse_a(logic [15:0] v);
        digits_in = v;
        load_a    = 1'b1;
        tick();
        load_a    = 1'b0;
    endtask

    logic [15:0] v;
    int fs;
    int c0;
    logic [15:0] rnd;

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        chk_en = 1'b1;
        chk("reset_number_a", 32'(number_a), 32'hF);
        chk("reset_sel_a", 32'(sel_a), 32'h0);
        chk("reset_sel_b", 32'(sel_b), 32'hF);
        rst_n = 1'b1;
        tick();
        chk("first_sel_a", 32'(sel_a), 32'h1);
        chk("first_number_a", 32'(number_a), 32'h0);
        grab(0, v, fs);
        chk("blank_after_reset", 32'(v), 32'hFFF0);

        // asynchronous reset in the middle of a scan
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        chk("async_reset_number", 32'(number_a), 32'hF);
        chk("async_reset_sel_a", 32'(sel_a), 32'h0);
        chk("async_reset_sel_b", 32'(sel_b), 32'hF);
        repeat (2) tick();
        rst_n = 1'b1;

        // commit timing
        wait_start(0);
        repeat (5) tick();
        c0 = upd_cnt_a;
        pulse_a(16'h1234);
        grab(0, v, fs);
        chk("commit_value", 32'(v), 32'h1234);
        chk("commit_upd_count", 32'(upd_cnt_a - c0), 32'd1);
        chk("commit_upd_timing", 32'(upd_last_a), 32'(fs - 1));

        // blanking on and off
        wait_start(0);
        tick();
        pulse_a(16'h0050);
        grab(0, v, fs);
        chk("blank_on", 32'(v), 32'hFF50);
        blank_en = 1'b0;
        grab(0, v, fs);
        chk("blank_off", 32'(v), 32'h0050);
        blank_en = 1'b1;

        // overwrite within one frame
        wait_start(0);
        tick();
        c0 = upd_cnt_a;
        pulse_a(16'h1111);
        tick();
        pulse_a(16'h2222);
        grab(0, v, fs);
        chk("overwrite_value", 32'(v), 32'h2222);
        grab(0, v, fs);
        chk("overwrite_hold", 32'(v), 32'h2222);
        chk("overwrite_upd_count", 32'(upd_cnt_a - c0), 32'd1);

        // load in exactly the boundary cycle while a value is pending
        wait_start(0);
        tick();
        c0 = upd_cnt_a;
        pulse_a(16'h4444);
        repeat (12) tick();
        pulse_a(16'h3333);
        grab(0, v, fs);
        chk("collision_first", 32'(v), 32'h4444);
        grab(0, v, fs);
        chk("collision_second", 32'(v), 32'h3333);
        chk("collision_upd_count", 32'(upd_cnt_a - c0), 32'd2);
        chk("collision_upd_gap", 32'(upd_last_a - upd_prev_a), 32'd16);

        // active-low select, one-cycle scan
        digits_in = 16'hA000;
        load_b    = 1'b1;
        tick();
        load_b    = 1'b0;
        repeat (8) tick();
        grab(1, v, fs);
        chk("polarity_value", 32'(v), 32'hA000);

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            for (int n = 0; n < 4; n++) begin
                rnd[4*n +: 4] = ($urandom_range(0, 3) < 2) ? 4'h0 : 4'($urandom_range(0, 15));
            end
            digits_in = rnd;
            load_a    = ($urandom_range(0, 5) == 0);
            load_b    = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 39) == 0) blank_en = ~blank_en;
            rst_n = ($urandom_range(0, 699) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        load_a = 1'b0;
        load_b = 1'b0;
        rst_n  = 1'b1;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
